// File: rtl/cp0_regfile_ext.sv
// cp0_regfile_ext: CP0 register file with Count prescaler, timer interrupt,
// synchronised hardware interrupts and a single exception/eret commit point.
//
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_raddr / o_rdata         mfc0 read port (combinational, with write bypass)
//   i_wen, i_waddr, i_wdata   mtc0 write port
//   i_exc_valid, i_exc_code,
//   i_exc_pc, i_exc_bd,
//   i_exc_badvaddr            exception commit from WB
//   i_eret                    eret commit from WB
//   i_hw_int                  asynchronous level hardware interrupts
//   o_int_req                 interrupt pending and enabled
//   o_flush, o_flush_target   pipeline flush and redirect address
//   o_status_exl              Status.EXL
module cp0_regfile_ext #(
   parameter int unsigned HW_INT_NUM = 6,
   parameter int unsigned COUNT_DIV  = 2,
   parameter logic [31:0] RESET_VEC  = 32'hbfc00000,
   parameter logic [31:0] EXC_VEC    = 32'hbfc00380
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [4:0]            i_raddr,
   output logic [31:0]           o_rdata,
   input  logic                  i_wen,
   input  logic [4:0]            i_waddr,
   input  logic [31:0]           i_wdata,
   input  logic                  i_exc_valid,
   input  logic [4:0]            i_exc_code,
   input  logic [31:0]           i_exc_pc,
   input  logic                  i_exc_bd,
   input  logic [31:0]           i_exc_badvaddr,
   input  logic                  i_eret,
   input  logic [HW_INT_NUM-1:0] i_hw_int,
   output logic                  o_int_req,
   output logic                  o_flush,
   output logic [31:0]           o_flush_target,
   output logic                  o_status_exl
);

   localparam logic [3:0] DIV_LAST = 4'(COUNT_DIV - 1);

   logic [31:0]           r_badvaddr;
   logic [31:0]           r_count;
   logic [31:0]           r_compare;
   logic [31:0]           r_epc;
   logic [7:0]            r_im;
   logic                  r_exl;
   logic                  r_ie;
   logic                  r_bd;
   logic                  r_ti;
   logic [1:0]            r_ip_sw;
   logic [4:0]            r_exccode;
   logic [3:0]            r_div_cnt;
   logic [HW_INT_NUM-1:0] r_sync1;
   logic [HW_INT_NUM-1:0] r_sync2;

   logic        w_wr_count;
   logic        w_wr_compare;
   logic        w_wr_status;
   logic        w_wr_cause;
   logic        w_wr_epc;
   logic        w_tick;
   logic [31:0] w_count_inc;
   logic        w_ti_set;
   logic [5:0]  w_hw_pad;
   logic [7:0]  w_ip;
   logic [7:0]  w_rd_im;
   logic        w_rd_exl;
   logic        w_rd_ie;
   logic [1:0]  w_rd_ip_sw;

   assign w_wr_count   = i_wen && (i_waddr == 5'd9);
   assign w_wr_compare = i_wen && (i_waddr == 5'd11);
   assign w_wr_status  = i_wen && (i_waddr == 5'd12);
   assign w_wr_cause   = i_wen && (i_waddr == 5'd13);
   assign w_wr_epc     = i_wen && (i_waddr == 5'd14);

   assign w_tick      = (r_div_cnt == DIV_LAST);
   assign w_count_inc = r_count + 32'd1;
   // A Count load replaces the increment, so it can never raise TI.
   assign w_ti_set    = w_tick && !w_wr_count && (w_count_inc == r_compare);

   // Zero-extending to six lines makes absent interrupt inputs read 0;
   // line 5 shares IP[7] with the timer.
   assign w_hw_pad = 6'(r_sync2);
   assign w_ip     = {r_ti | w_hw_pad[5], w_hw_pad[4:0], r_ip_sw};

   assign o_int_req      = r_ie & ~r_exl & |(w_ip & r_im);
   assign o_flush        = i_exc_valid | i_eret;
   assign o_flush_target = (i_eret && !i_exc_valid) ? r_epc : EXC_VEC;
   assign o_status_exl   = r_exl;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_badvaddr <= RESET_VEC;
         r_count    <= '0;
         r_compare  <= '0;
         r_epc      <= RESET_VEC;
         r_im       <= '0;
         r_exl      <= 1'b0;
         r_ie       <= 1'b0;
         r_bd       <= 1'b0;
         r_ti       <= 1'b0;
         r_ip_sw    <= '0;
         r_exccode  <= '0;
         r_div_cnt  <= '0;
         r_sync1    <= '0;
         r_sync2    <= '0;
      end else begin
         r_sync1 <= i_hw_int;
         r_sync2 <= r_sync1;

         if (w_wr_count) begin
            r_count   <= i_wdata;
            r_div_cnt <= '0;
         end else if (w_tick) begin
            r_count   <= w_count_inc;
            r_div_cnt <= '0;
         end else begin
            r_div_cnt <= r_div_cnt + 4'd1;
         end

         if (w_wr_compare) r_compare <= i_wdata;

         if (w_wr_compare)  r_ti <= 1'b0;
         else if (w_ti_set) r_ti <= 1'b1;

         if (i_exc_valid) begin
            r_exccode <= i_exc_code;
            r_exl     <= 1'b1;
            // Nested exceptions keep the original return point.
            if (!r_exl) begin
               r_epc <= i_exc_bd ? (i_exc_pc - 32'd4) : i_exc_pc;
               r_bd  <= i_exc_bd;
            end
            if (i_exc_code == 5'd4 || i_exc_code == 5'd5)
               r_badvaddr <= i_exc_badvaddr;
         end else begin
            if (w_wr_status) begin
               r_im <= i_wdata[15:8];
               r_ie <= i_wdata[0];
            end
            if (w_wr_cause) r_ip_sw <= i_wdata[9:8];
            if (i_eret) begin
               r_exl <= 1'b0;
            end else begin
               if (w_wr_status) r_exl <= i_wdata[1];
               if (w_wr_epc)    r_epc <= i_wdata;
            end
         end
      end
   end

   // Read bypass: a same-cycle mtc0 shows its post-write value.
   assign w_rd_im    = w_wr_status ? i_wdata[15:8] : r_im;
   assign w_rd_exl   = w_wr_status ? i_wdata[1]    : r_exl;
   assign w_rd_ie    = w_wr_status ? i_wdata[0]    : r_ie;
   assign w_rd_ip_sw = w_wr_cause  ? i_wdata[9:8]  : r_ip_sw;

   always_comb begin
      o_rdata = '0;
      case (i_raddr)
         5'd8:  o_rdata = r_badvaddr;
         5'd9:  o_rdata = w_wr_count   ? i_wdata : r_count;
         5'd11: o_rdata = w_wr_compare ? i_wdata : r_compare;
         5'd12: o_rdata = {9'b0, 1'b1, 6'b0, w_rd_im, 6'b0, w_rd_exl, w_rd_ie};
         5'd13: o_rdata = {r_bd, r_ti, 14'b0, w_ip[7:2], w_rd_ip_sw,
                           1'b0, r_exccode, 2'b0};
         5'd14: o_rdata = w_wr_epc     ? i_wdata : r_epc;
         default: o_rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_cp0_regfile_ext.sv
module tb_cp0_regfile_ext;

   logic        clk;
   logic        rst;
   logic [4:0]  raddr;
   logic [31:0] rdata;
   logic        wen;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        exc_valid;
   logic [4:0]  exc_code;
   logic [31:0] exc_pc;
   logic        exc_bd;
   logic [31:0] exc_badvaddr;
   logic        eret;
   logic [5:0]  hw_int;
   logic        int_req;
   logic        flush;
   logic [31:0] flush_target;
   logic        status_exl;

   cp0_regfile_ext dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_raddr        (raddr),
      .o_rdata        (rdata),
      .i_wen          (wen),
      .i_waddr        (waddr),
      .i_wdata        (wdata),
      .i_exc_valid    (exc_valid),
      .i_exc_code     (exc_code),
      .i_exc_pc       (exc_pc),
      .i_exc_bd       (exc_bd),
      .i_exc_badvaddr (exc_badvaddr),
      .i_eret         (eret),
      .i_hw_int       (hw_int),
      .o_int_req      (int_req),
      .o_flush        (flush),
      .o_flush_target (flush_target),
      .o_status_exl   (status_exl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam int S_RDATA = 0;
   localparam int S_INTREQ = 1;
   localparam int S_FLUSH = 2;
   localparam int S_TARGET = 3;
   localparam int S_EXL = 4;

   string       q_name[$];
   int          q_sel[$];
   logic [31:0] q_exp[$];

   int total = 0;
   int bad   = 0;

   string       m_nm;
   int          m_sel;
   logic [31:0] m_exp;
   logic [31:0] m_act;

   // Monitor: every expectation queued during a cycle is checked at the
   // falling edge of that cycle.
   always @(negedge clk) begin
      while (q_sel.size() > 0) begin
         m_nm  = q_name.pop_front();
         m_sel = q_sel.pop_front();
         m_exp = q_exp.pop_front();
         case (m_sel)
            S_RDATA:  m_act = rdata;
            S_INTREQ: m_act = {31'b0, int_req};
            S_FLUSH:  m_act = {31'b0, flush};
            S_TARGET: m_act = flush_target;
            default:  m_act = {31'b0, status_exl};
         endcase
         total++;
         if (m_act !== m_exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", m_nm, m_act, m_exp);
         end
      end
   end

   task automatic push(input string nm, input int sel, input logic [31:0] e);
      q_name.push_back(nm);
      q_sel.push_back(sel);
      q_exp.push_back(e);
   endtask

   task automatic rd(input string nm, input logic [4:0] a, input logic [31:0] e);
      raddr = a;
      push(nm, S_RDATA, e);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      wen       = 1'b0;
      exc_valid = 1'b0;
      eret      = 1'b0;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      wen   = 1'b1;
      waddr = a;
      wdata = d;
   endtask

   task automatic exc(input logic [4:0] code, input logic [31:0] pc,
                      input logic bd, input logic [31:0] bva);
      exc_valid    = 1'b1;
      exc_code     = code;
      exc_pc       = pc;
      exc_bd       = bd;
      exc_badvaddr = bva;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; raddr = '0; wen = 1'b0; waddr = '0; wdata = '0;
      exc_valid = 1'b0; exc_code = '0; exc_pc = '0; exc_bd = 1'b0;
      exc_badvaddr = '0; eret = 1'b0; hw_int = '0;
      cyc(); cyc();

      // Reset values, read while reset is still held so Count stays 0.
      rd("rst_badvaddr", 5'd8, 32'hbfc00000);
      push("rst_intreq", S_INTREQ, 32'd0);
      push("rst_flush", S_FLUSH, 32'd0);
      push("rst_target", S_TARGET, 32'hbfc00380);
      push("rst_exl", S_EXL, 32'd0);
      cyc();
      rd("rst_count", 5'd9, 32'd0); cyc();
      rd("rst_compare", 5'd11, 32'd0); cyc();
      rd("rst_status", 5'd12, 32'h00400000); cyc();
      rd("rst_cause", 5'd13, 32'd0); cyc();
      rd("rst_epc", 5'd14, 32'hbfc00000); cyc();
      rd("rst_unmapped", 5'd15, 32'd0); cyc();

      rst = 1'b0;
      repeat (10) cyc();
      rd("count_after10", 5'd9, 32'd5); cyc();

      // Timer interrupt.
      wr(5'd9, 32'd0);  rd("byp_count", 5'd9, 32'd0); cyc();
      wr(5'd11, 32'd3); rd("byp_compare", 5'd11, 32'd3); cyc();
      wr(5'd12, 32'h8001); rd("byp_status", 5'd12, 32'h00408001); cyc();
      rd("ti_early", 5'd13, 32'd0); push("intreq_early", S_INTREQ, 32'd0); cyc();
      cyc(); cyc();
      rd("ti_before", 5'd13, 32'd0); push("intreq_before", S_INTREQ, 32'd0); cyc();
      rd("ti_set", 5'd13, 32'h40008000); push("intreq_timer", S_INTREQ, 32'd1); cyc();
      rd("count_at3", 5'd9, 32'd3); cyc();
      rd("ti_sticky", 5'd13, 32'h40008000); cyc();
      wr(5'd11, 32'd100); cyc();
      rd("ti_clear", 5'd13, 32'd0); push("intreq_tclr", S_INTREQ, 32'd0); cyc();

      // Hardware interrupt line 0 -> IP[2], two-cycle latency.
      wr(5'd12, 32'h0401); cyc();
      hw_int = 6'b000001;
      rd("hw_lat0", 5'd13, 32'd0); push("hw_int_lat0", S_INTREQ, 32'd0); cyc();
      push("hw_int_lat1", S_INTREQ, 32'd0); cyc();
      rd("hw_ip2", 5'd13, 32'h00000400); push("hw_int_on", S_INTREQ, 32'd1); cyc();
      hw_int = 6'b000000;
      push("hw_off_lat0", S_INTREQ, 32'd1); cyc();
      push("hw_off_lat1", S_INTREQ, 32'd1); cyc();
      rd("hw_ip2_off", 5'd13, 32'd0); push("hw_int_off", S_INTREQ, 32'd0); cyc();
      // Lines 4 and 5 map to IP[6] and IP[7]; masked so no request.
      hw_int = 6'b110000; cyc(); cyc();
      rd("hw_ip67", 5'd13, 32'h0000c000); push("hw_ip67_mask", S_INTREQ, 32'd0);
      hw_int = 6'b000000; cyc(); cyc();
      rd("hw_ip67_off", 5'd13, 32'd0); cyc();

      // Exception commit.
      exc(5'd4, 32'hbfc00104, 1'b1, 32'h00001001);
      push("exc_flush", S_FLUSH, 32'd1);
      push("exc_target", S_TARGET, 32'hbfc00380);
      cyc();
      rd("exc_epc", 5'd14, 32'hbfc00100); push("exc_exl", S_EXL, 32'd1);
      push("exc_intreq", S_INTREQ, 32'd0); cyc();
      rd("exc_badvaddr", 5'd8, 32'h00001001); cyc();
      rd("exc_cause", 5'd13, 32'h80000010); cyc();
      exc(5'd8, 32'h12345678, 1'b0, 32'hdeadbeef);
      wr(5'd12, 32'hff03);
      push("exc2_target", S_TARGET, 32'hbfc00380);
      cyc();
      rd("exc2_epc", 5'd14, 32'hbfc00100); cyc();
      rd("exc2_cause", 5'd13, 32'h80000020); cyc();
      rd("exc2_badvaddr", 5'd8, 32'h00001001); cyc();
      rd("exc2_status", 5'd12, 32'h00400403); cyc();

      // eret.
      wr(5'd14, 32'hbfc00200); rd("byp_epc", 5'd14, 32'hbfc00200); cyc();
      eret = 1'b1;
      push("eret_flush", S_FLUSH, 32'd1);
      push("eret_target", S_TARGET, 32'hbfc00200);
      push("eret_exl_before", S_EXL, 32'd1);
      cyc();
      push("eret_exl_after", S_EXL, 32'd0);
      push("idle_flush", S_FLUSH, 32'd0);
      push("idle_target", S_TARGET, 32'hbfc00380);
      cyc();
      exc(5'd0, 32'h80000010, 1'b0, 32'd0); eret = 1'b1;
      push("both_target", S_TARGET, 32'hbfc00380);
      cyc();
      push("both_exl", S_EXL, 32'd1); rd("both_epc", 5'd14, 32'h80000010); cyc();
      exc(5'd0, 32'h11111111, 1'b0, 32'd0); eret = 1'b1;
      push("both2_target", S_TARGET, 32'hbfc00380);
      cyc();
      push("both2_exl", S_EXL, 32'd1); rd("both2_epc", 5'd14, 32'h80000010); cyc();

      // EPC bypass, Count wrap, unmapped write.
      wr(5'd14, 32'h1234); rd("byp_epc2", 5'd14, 32'h1234); cyc();
      rd("epc_held", 5'd14, 32'h1234); cyc();
      wr(5'd9, 32'hffffffff); rd("byp_count_max", 5'd9, 32'hffffffff); cyc();
      rd("count_max0", 5'd9, 32'hffffffff); cyc();
      rd("count_max1", 5'd9, 32'hffffffff); cyc();
      rd("count_wrap", 5'd9, 32'd0); cyc();
      wr(5'd10, 32'hffffffff); rd("unmapped_wr", 5'd10, 32'd0); cyc();

      // Software interrupt via Cause.IP[1:0].
      wr(5'd13, 32'hffffffff); rd("byp_cause", 5'd13, 32'h00000300); cyc();
      wr(5'd12, 32'h0101); cyc();
      push("sw_intreq", S_INTREQ, 32'd1); cyc();

      // Reset dominates a same-cycle exception.
      rst = 1'b1; exc(5'd4, 32'h22222222, 1'b1, 32'h33333333); cyc();
      rst = 1'b0;
      rd("rstdom_epc", 5'd14, 32'hbfc00000); push("rstdom_exl", S_EXL, 32'd0); cyc();
      rd("rstdom_badvaddr", 5'd8, 32'hbfc00000); cyc();
      rd("rstdom_status", 5'd12, 32'h00400000); cyc();

      @(negedge clk);
      #1;
      total++;
      if (q_sel.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d want 0", q_sel.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
